// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: per-register hold/clear, PC hold,
// fetch kill, fence.i drain sequencing and stall/flush perf counters.
module pipe_hazard_ctrl #(
   parameter int CNT_W = 64,
   parameter int RA_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_busy_i,
   input  logic             if_ack_i,
   input  logic             mem_busy_i,
   input  logic             ex_busy_i,
   input  logic             id_rs1_ren_i,
   input  logic             id_rs2_ren_i,
   input  logic [RA_W-1:0]  id_rs1_i,
   input  logic [RA_W-1:0]  id_rs2_i,
   input  logic             ex_load_i,
   input  logic [RA_W-1:0]  ex_rd_i,
   input  logic             ex_redirect_i,
   input  logic             wb_trap_i,
   input  logic             id_fencei_i,
   input  logic [2:0]       pipe_vld_i,
   output logic [3:0]       hold_o,
   output logic [3:0]       clear_o,
   output logic             pc_hold_o,
   output logic             fetch_kill_o,
   output logic             fencei_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      FENCE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic             trap_pend;
   logic             kill;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic       trap_go;
   logic       load_use;
   logic       fetch_stall;
   logic       redirect_go;
   logic       flush_go;
   logic       rule_act;
   logic       fence_fire;
   logic [3:0] hold_c;
   logic [3:0] clear_c;
   logic       pc_hold_c;

   always_comb begin
      trap_go     = (wb_trap_i | trap_pend) & ~mem_busy_i;
      load_use    = ex_load_i & (ex_rd_i != '0) &
                    ((id_rs1_ren_i & (id_rs1_i == ex_rd_i)) |
                     (id_rs2_ren_i & (id_rs2_i == ex_rd_i)));
      fetch_stall = if_busy_i & ~if_ack_i;
      // A redirect waiting behind a bus or mul/div stall fires once the stall ends.
      redirect_go = ex_redirect_i & ~trap_go & ~mem_busy_i & ~ex_busy_i;
      flush_go    = trap_go | redirect_go;
      rule_act    = trap_go | mem_busy_i | ex_busy_i | ex_redirect_i | load_use;

      hold_c     = 4'b0000;
      clear_c    = 4'b0000;
      pc_hold_c  = 1'b0;
      fence_fire = 1'b0;
      if (trap_go) begin
         clear_c = 4'b1111;
      end else if (mem_busy_i) begin
         hold_c    = 4'b0111;
         clear_c   = 4'b1000;
         pc_hold_c = 1'b1;
      end else if (ex_busy_i) begin
         hold_c    = 4'b0011;
         clear_c   = 4'b0100;
         pc_hold_c = 1'b1;
      end else if (ex_redirect_i) begin
         clear_c = 4'b0011;
      end else if (load_use || state == DRAIN) begin
         hold_c    = 4'b0001;
         clear_c   = 4'b0010;
         pc_hold_c = 1'b1;
      end else if (state == FENCE) begin
         clear_c    = 4'b0001;
         fence_fire = 1'b1;
      end else if (fetch_stall) begin
         clear_c   = 4'b0001;
         pc_hold_c = 1'b1;
      end
      if (kill) clear_c[0] = 1'b1;
      hold_c = hold_c & ~clear_c;
   end

   assign hold_o       = rst_n ? hold_c  : 4'b0000;
   assign clear_o      = rst_n ? clear_c : 4'b1111;
   assign pc_hold_o    = rst_n & pc_hold_c;
   assign fetch_kill_o = rst_n & kill;
   assign fencei_o     = rst_n & fence_fire;
   assign stall_cnt_o  = stall_cnt;
   assign flush_cnt_o  = flush_cnt;
   assign state_o      = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         trap_pend <= 1'b0;
         kill      <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (trap_go)                      trap_pend <= 1'b0;
         else if (wb_trap_i && mem_busy_i) trap_pend <= 1'b1;

         // The fetch in flight at flush time belongs to the squashed path.
         if (flush_go && fetch_stall)  kill <= 1'b1;
         else if (kill && if_ack_i)    kill <= 1'b0;

         if (flush_go) begin
            state <= RUN;
         end else begin
            case (state)
               RUN:     if (id_fencei_i && !rule_act) state <= DRAIN;
               DRAIN:   if (pipe_vld_i == 3'b000 && !mem_busy_i) state <= FENCE;
               FENCE:   if (fence_fire) state <= RUN;
               default: state <= RUN;
            endcase
         end

         if ((|hold_c) || pc_hold_c) stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_go)               flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: each step queues the expected
// output vector and compares it mid-cycle against the combinational outputs.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 64;
   localparam int RA_W  = 5;
   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_FENCE = 2'd2;

   logic             clk;
   logic             rst_n;
   logic             if_busy_i, if_ack_i, mem_busy_i, ex_busy_i;
   logic             id_rs1_ren_i, id_rs2_ren_i;
   logic [RA_W-1:0]  id_rs1_i, id_rs2_i, ex_rd_i;
   logic             ex_load_i, ex_redirect_i, wb_trap_i, id_fencei_i;
   logic [2:0]       pipe_vld_i;
   logic [3:0]       hold_o, clear_o;
   logic             pc_hold_o, fetch_kill_o, fencei_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
   logic [1:0]       state_o;

   logic [12:0]      exp_q[$];
   int               n_cmp;
   int               n_bad;
   logic [CNT_W-1:0] exp_stall;
   logic [CNT_W-1:0] exp_flush;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .RA_W(RA_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_busy_i     (if_busy_i),
      .if_ack_i      (if_ack_i),
      .mem_busy_i    (mem_busy_i),
      .ex_busy_i     (ex_busy_i),
      .id_rs1_ren_i  (id_rs1_ren_i),
      .id_rs2_ren_i  (id_rs2_ren_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .ex_load_i     (ex_load_i),
      .ex_rd_i       (ex_rd_i),
      .ex_redirect_i (ex_redirect_i),
      .wb_trap_i     (wb_trap_i),
      .id_fencei_i   (id_fencei_i),
      .pipe_vld_i    (pipe_vld_i),
      .hold_o        (hold_o),
      .clear_o       (clear_o),
      .pc_hold_o     (pc_hold_o),
      .fetch_kill_o  (fetch_kill_o),
      .fencei_o      (fencei_o),
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o),
      .state_o       (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      if_busy_i = 0; if_ack_i = 0; mem_busy_i = 0; ex_busy_i = 0;
      id_rs1_ren_i = 0; id_rs2_ren_i = 0; id_rs1_i = '0; id_rs2_i = '0;
      ex_load_i = 0; ex_rd_i = '0; ex_redirect_i = 0; wb_trap_i = 0;
      id_fencei_i = 0; pipe_vld_i = 3'b000;
   endtask

   // One cycle: queue the expected vector, compare at the falling edge, step past the rising edge.
   task automatic cyc(input string tag, input logic [3:0] h, input logic [3:0] c,
                      input logic pc, input logic fk, input logic fi,
                      input logic [1:0] st, input logic fl);
      logic [12:0] e;
      logic [12:0] o;
      exp_q.push_back({h, c, pc, fk, fi, st});
      if (rst_n && (|h || pc)) exp_stall = exp_stall + 1;
      if (rst_n && fl)         exp_flush = exp_flush + 1;
      @(negedge clk);
      o = {hold_o, clear_o, pc_hold_o, fetch_kill_o, fencei_o, state_o};
      e = exp_q.pop_front();
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s: got hold=%b clear=%b pc_hold=%b kill=%b fencei=%b state=%0d, expected hold=%b clear=%b pc_hold=%b kill=%b fencei=%b state=%0d",
                tag, o[12:9], o[8:5], o[4], o[3], o[2], o[1:0],
                e[12:9], e[8:5], e[4], e[3], e[2], e[1:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag);
      n_cmp++;
      assert (stall_cnt_o === exp_stall) else begin
         n_bad++;
         $error("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt_o, exp_stall);
      end
      n_cmp++;
      assert (flush_cnt_o === exp_flush) else begin
         n_bad++;
         $error("FAIL %s flush_cnt: got %0d expected %0d", tag, flush_cnt_o, exp_flush);
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; exp_stall = '0; exp_flush = '0;
      idle();
      rst_n = 0;
      @(posedge clk); #1;
      cyc("reset_out", 4'b0000, 4'b1111, 0, 0, 0, S_RUN, 0);
      chk_cnt("reset_cnt");
      rst_n = 1;
      cyc("idle", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);

      // load-use
      ex_load_i = 1; ex_rd_i = 5; id_rs1_i = 5; id_rs1_ren_i = 1;
      cyc("lu_rs1", 4'b0001, 4'b0010, 1, 0, 0, S_RUN, 0);
      ex_rd_i = 0; id_rs1_i = 0;
      cyc("lu_rd0", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);
      ex_rd_i = 7; id_rs1_i = 3; id_rs2_i = 7; id_rs2_ren_i = 1;
      cyc("lu_rs2", 4'b0001, 4'b0010, 1, 0, 0, S_RUN, 0);
      id_rs2_ren_i = 0;
      cyc("lu_noren", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);
      idle();
      chk_cnt("t1_cnt");

      // bus / mul-div stalls masking a redirect
      mem_busy_i = 1; ex_redirect_i = 1;
      for (int i = 0; i < 3; i++)
         cyc("mem_stall", 4'b0111, 4'b1000, 1, 0, 0, S_RUN, 0);
      mem_busy_i = 0;
      cyc("redir_after_mem", 4'b0000, 4'b0011, 0, 0, 0, S_RUN, 1);
      ex_busy_i = 1;
      cyc("ex_stall", 4'b0011, 4'b0100, 1, 0, 0, S_RUN, 0);
      ex_busy_i = 0;
      cyc("redir_after_ex", 4'b0000, 4'b0011, 0, 0, 0, S_RUN, 1);
      idle();
      chk_cnt("t2_cnt");

      // redirect with a fetch in flight
      ex_redirect_i = 1; if_busy_i = 1;
      cyc("redir_fetch", 4'b0000, 4'b0011, 0, 0, 0, S_RUN, 1);
      ex_redirect_i = 0;
      cyc("kill_wait", 4'b0000, 4'b0001, 1, 1, 0, S_RUN, 0);
      if_busy_i = 0; if_ack_i = 1;
      cyc("kill_ack", 4'b0000, 4'b0001, 0, 1, 0, S_RUN, 0);
      idle();
      cyc("kill_done", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);

      // trap deferred behind a busy bus
      wb_trap_i = 1; mem_busy_i = 1;
      cyc("trap_mem1", 4'b0111, 4'b1000, 1, 0, 0, S_RUN, 0);
      wb_trap_i = 0;
      cyc("trap_mem2", 4'b0111, 4'b1000, 1, 0, 0, S_RUN, 0);
      mem_busy_i = 0;
      cyc("trap_go", 4'b0000, 4'b1111, 0, 0, 0, S_RUN, 1);
      cyc("trap_once", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);
      chk_cnt("t4_cnt");

      // fence.i drain
      id_fencei_i = 1; pipe_vld_i = 3'b111;
      cyc("fence_enter", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);
      pipe_vld_i = 3'b110;
      cyc("drain1", 4'b0001, 4'b0010, 1, 0, 0, S_DRAIN, 0);
      pipe_vld_i = 3'b100;
      cyc("drain2", 4'b0001, 4'b0010, 1, 0, 0, S_DRAIN, 0);
      pipe_vld_i = 3'b000;
      cyc("drain3", 4'b0001, 4'b0010, 1, 0, 0, S_DRAIN, 0);
      id_fencei_i = 0;
      cyc("fence_pulse", 4'b0000, 4'b0001, 0, 0, 1, S_FENCE, 0);
      cyc("fence_done", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);

      // redirect squashes a drain; the kill it leaves carries into the next drain
      id_fencei_i = 1; pipe_vld_i = 3'b001;
      cyc("fence2_enter", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);
      ex_redirect_i = 1; if_busy_i = 1;
      cyc("drain_redir", 4'b0000, 4'b0011, 0, 0, 0, S_DRAIN, 1);
      ex_redirect_i = 0;
      cyc("squash_run", 4'b0000, 4'b0001, 1, 1, 0, S_RUN, 0);
      cyc("drain_kill", 4'b0000, 4'b0011, 1, 1, 0, S_DRAIN, 0);
      chk_cnt("pre_rst_cnt");

      // reset mid-drain with kill pending
      rst_n = 0;
      cyc("rst_in_drain", 4'b0000, 4'b1111, 0, 0, 0, S_DRAIN, 0);
      exp_stall = '0; exp_flush = '0;
      idle();
      cyc("rst_state", 4'b0000, 4'b1111, 0, 0, 0, S_RUN, 0);
      chk_cnt("rst_cnt");
      rst_n = 1;
      cyc("post_rst", 4'b0000, 4'b0000, 0, 0, 0, S_RUN, 0);
      chk_cnt("post_rst_cnt");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
